// File: rtl/computedram_seq_if.sv
// Request/command bus of the ComputeDRAM row-operation sequencer.
// The master side is the user logic plus the PHY command arbiter; the slave
// side is the sequencer itself.
interface computedram_seq_if #(
    parameter int ROW_W = 15,
    parameter int BA_W  = 3,
    parameter int T_W   = 4
);
    // Request queue side
    logic             req_valid;
    logic             req_ready;
    logic             req_mode;
    logic [BA_W-1:0]  req_bank;
    logic [ROW_W-1:0] req_r1;
    logic [ROW_W-1:0] req_r2;
    logic [T_W-1:0]   req_t1;
    logic [T_W-1:0]   req_t2;

    // Command side toward the arbiter
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [BA_W-1:0]  cmd_bank;
    logic [ROW_W-1:0] cmd_addr;

    modport master (
        output req_valid, req_mode, req_bank, req_r1, req_r2, req_t1, req_t2,
        output cmd_ready,
        input  req_ready,
        input  cmd_valid, cmd_type, cmd_bank, cmd_addr
    );

    modport slave (
        input  req_valid, req_mode, req_bank, req_r1, req_r2, req_t1, req_t2,
        input  cmd_ready,
        output req_ready,
        output cmd_valid, cmd_type, cmd_bank, cmd_addr
    );
endinterface

// File: rtl/computedram_seq.sv
// ComputeDRAM row-operation sequencer.
// Queues requests (valid/ready, DEPTH entries) and expands each one into a
// timed ACT/PRE command sequence toward the PHY command arbiter, pulsing
// done once per finished operation.
// Optional statistics counters are built only when COMPUTEDRAM_STATS_EN is
// defined; otherwise stat_ops/stat_stall are tied to zero.
module computedram_seq #(
    parameter int ROW_W = 15,
    parameter int BA_W  = 3,
    parameter int T_W   = 4,
    parameter int DEPTH = 4,
    parameter int TRAS  = 8,
    parameter int TRP   = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    computedram_seq_if.slave         bus,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_stall
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W0 = (T_W > $clog2(TRAS + 1)) ? T_W : $clog2(TRAS + 1);
    localparam int CNT_W  = (CNT_W0 > $clog2(TRP + 1)) ? CNT_W0 : $clog2(TRP + 1);

    localparam logic [1:0] CMD_ACT = 2'd1;
    localparam logic [1:0] CMD_PRE = 2'd2;

    // Final precharge sets only address bit 10 (precharge-all)
    localparam logic [ROW_W-1:0] PRE_ALL = (ROW_W'(1) << 10);

    // Fixed-delay reload values; only used when the delay is non-zero
    localparam logic [CNT_W-1:0] TRAS_LD = (TRAS > 0) ? CNT_W'(TRAS - 1) : '0;
    localparam logic [CNT_W-1:0] TRP_LD  = (TRP  > 0) ? CNT_W'(TRP  - 1) : '0;

    typedef struct packed {
        logic             mode;
        logic [BA_W-1:0]  bank;
        logic [ROW_W-1:0] r1;
        logic [ROW_W-1:0] r2;
        logic [T_W-1:0]   t1;
        logic [T_W-1:0]   t2;
    } req_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT1,
        S_WAIT1,
        S_PRE1,
        S_WAIT2,
        S_ACT2,
        S_WAIT_RAS,
        S_PRE2,
        S_WAIT_RP,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    req_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    req_t             w_in;
    req_t             w_head;
    logic             w_req_ready;
    logic             w_push;
    logic             w_pop;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    req_t             r_wk;

    assign w_in.mode = bus.req_mode;
    assign w_in.bank = bus.req_bank;
    assign w_in.r1   = bus.req_r1;
    assign w_in.r2   = bus.req_r2;
    assign w_in.t1   = bus.req_t1;
    assign w_in.t2   = bus.req_t2;

    assign w_req_ready   = (r_level < LVL_W'(DEPTH));
    assign w_push        = bus.req_valid && w_req_ready;
    assign w_pop         = (r_state == S_IDLE) && (r_level != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign bus.req_ready = w_req_ready;

    // Queue storage: left unreset so it maps onto plain RAM
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // Queue pointers and occupancy; push+pop together keeps the level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    // Next state and wait counter; a delay of zero skips its wait state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_next = S_ACT1;
                end
            end
            S_ACT1: begin
                if (bus.cmd_ready) begin
                    if (r_wk.t1 == '0) begin
                        w_state_next = S_PRE1;
                    end else begin
                        w_state_next = S_WAIT1;
                        w_cnt_next   = CNT_W'(r_wk.t1) - CNT_W'(1);
                    end
                end
            end
            S_WAIT1: begin
                if (r_cnt == '0) begin
                    w_state_next = S_PRE1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_PRE1: begin
                if (bus.cmd_ready) begin
                    if (r_wk.mode) begin
                        // Single-row op: no second ACT, go to precharge recovery
                        if (TRP == 0) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_WAIT_RP;
                            w_cnt_next   = TRP_LD;
                        end
                    end else if (r_wk.t2 == '0) begin
                        w_state_next = S_ACT2;
                    end else begin
                        w_state_next = S_WAIT2;
                        w_cnt_next   = CNT_W'(r_wk.t2) - CNT_W'(1);
                    end
                end
            end
            S_WAIT2: begin
                if (r_cnt == '0) begin
                    w_state_next = S_ACT2;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_ACT2: begin
                if (bus.cmd_ready) begin
                    if (TRAS == 0) begin
                        w_state_next = S_PRE2;
                    end else begin
                        w_state_next = S_WAIT_RAS;
                        w_cnt_next   = TRAS_LD;
                    end
                end
            end
            S_WAIT_RAS: begin
                if (r_cnt == '0) begin
                    w_state_next = S_PRE2;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_PRE2: begin
                if (bus.cmd_ready) begin
                    if (TRP == 0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_WAIT_RP;
                        w_cnt_next   = TRP_LD;
                    end
                end
            end
            S_WAIT_RP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Fields of the op that will be current next cycle (fresh pop or held)
    logic [BA_W-1:0]  w_nxt_bank;
    logic [ROW_W-1:0] w_nxt_r1;
    logic [ROW_W-1:0] w_nxt_r2;

    assign w_nxt_bank = w_pop ? w_head.bank : r_wk.bank;
    assign w_nxt_r1   = w_pop ? w_head.r1   : r_wk.r1;
    assign w_nxt_r2   = w_pop ? w_head.r2   : r_wk.r2;

    // Command outputs decoded from the next state so they leave a register
    logic             w_cmd_valid_next;
    logic [1:0]       w_cmd_type_next;
    logic [BA_W-1:0]  w_cmd_bank_next;
    logic [ROW_W-1:0] w_cmd_addr_next;

    always_comb begin
        w_cmd_valid_next = 1'b0;
        w_cmd_type_next  = 2'd0;
        w_cmd_bank_next  = '0;
        w_cmd_addr_next  = '0;
        case (w_state_next)
            S_ACT1: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_type_next  = CMD_ACT;
                w_cmd_bank_next  = w_nxt_bank;
                w_cmd_addr_next  = w_nxt_r1;
            end
            S_PRE1: begin
                // Intermediate precharge is always single-bank (address 0)
                w_cmd_valid_next = 1'b1;
                w_cmd_type_next  = CMD_PRE;
                w_cmd_bank_next  = w_nxt_bank;
            end
            S_ACT2: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_type_next  = CMD_ACT;
                w_cmd_bank_next  = w_nxt_bank;
                w_cmd_addr_next  = w_nxt_r2;
            end
            S_PRE2: begin
                w_cmd_valid_next = 1'b1;
                w_cmd_type_next  = CMD_PRE;
                w_cmd_bank_next  = w_nxt_bank;
                w_cmd_addr_next  = PRE_ALL;
            end
            default: begin
            end
        endcase
    end

    logic             r_cmd_valid;
    logic [1:0]       r_cmd_type;
    logic [BA_W-1:0]  r_cmd_bank;
    logic [ROW_W-1:0] r_cmd_addr;
    logic             r_done;

    // FSM state, working op and registered command/done outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wk        <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= 2'd0;
            r_cmd_bank  <= '0;
            r_cmd_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            if (w_pop) begin
                r_wk <= w_head;
            end
            r_cmd_valid <= w_cmd_valid_next;
            r_cmd_type  <= w_cmd_type_next;
            r_cmd_bank  <= w_cmd_bank_next;
            r_cmd_addr  <= w_cmd_addr_next;
            r_done      <= (w_state_next == S_DONE);
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_type  = r_cmd_type;
    assign bus.cmd_bank  = r_cmd_bank;
    assign bus.cmd_addr  = r_cmd_addr;
    assign done          = r_done;
    assign busy          = (r_state != S_IDLE) || (r_level != '0);
    assign level         = r_level;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef COMPUTEDRAM_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_stall;

    // Saturating counters of finished ops and back-pressured command cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_done && (r_stat_ops != 32'hFFFF_FFFF)) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (r_cmd_valid && !bus.cmd_ready && (r_stat_stall != 32'hFFFF_FFFF)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`else
    assign stat_ops   = 32'd0;
    assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_computedram_seq.sv
// Directed bench for computedram_seq: cycle-exact ACT/PRE timing, back-pressure,
// queue fill order and mid-op reset. Cycle numbers are the bench cycle counter
// value observed on the falling edge; a push at cycle k is accepted at the
// rising edge ending cycle k.
module tb_computedram_seq;
    localparam int ROW_W = 15;
    localparam int BA_W  = 3;
    localparam int T_W   = 4;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    computedram_seq_if #(.ROW_W(ROW_W), .BA_W(BA_W), .T_W(T_W)) bus();

    logic             done;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic [31:0]      stat_ops;
    logic [31:0]      stat_stall;

    computedram_seq #(
        .ROW_W(ROW_W), .BA_W(BA_W), .T_W(T_W),
        .DEPTH(DEPTH), .TRAS(8), .TRP(4)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus),
        .done       (done),
        .busy       (busy),
        .level      (level),
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accepted commands and done pulses, sampled on the falling edge
    int ev_cyc[$];
    int ev_type[$];
    int ev_addr[$];
    int ev_bank[$];
    int done_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                ev_cyc.push_back(cyc);
                ev_type.push_back(int'(bus.cmd_type));
                ev_addr.push_back(int'(bus.cmd_addr));
                ev_bank.push_back(int'(bus.cmd_bank));
                $display("[TB] cyc %0d cmd type=%0d bank=%0d addr=0x%0h",
                         cyc, bus.cmd_type, bus.cmd_bank, bus.cmd_addr);
            end
            if (done) begin
                done_q.push_back(cyc);
                $display("[TB] cyc %0d done", cyc);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int push_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_type.delete();
        ev_addr.delete();
        ev_bank.delete();
        done_q.delete();
    endtask

    // Present one request; returns one cycle after the accepting edge
    task automatic push(input logic mode, input int bank, input int r1, input int r2,
                        input int t1, input int t2);
        int guard;
        guard = 0;
        bus.req_mode  = mode;
        bus.req_bank  = BA_W'(bank);
        bus.req_r1    = ROW_W'(r1);
        bus.req_r2    = ROW_W'(r2);
        bus.req_t1    = T_W'(t1);
        bus.req_t2    = T_W'(t2);
        bus.req_valid = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", 32'(bus.req_ready), 32'd1);
        push_cyc = cyc;
        $display("[TB] cyc %0d push mode=%0d bank=%0d r1=%0d r2=%0d t1=%0d t2=%0d",
                 cyc, mode, bank, r1, r2, t1, t2);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int b;
        b = 0;
        while (done_q.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("done_count", 32'(done_q.size()), 32'(n));
        @(posedge clk);
        #2;
    endtask

    task automatic check_ev(input int i, input string name, input int c, input int t,
                            input int a, input int b);
        if (i < ev_cyc.size()) begin
            check({name, "_cyc"},  32'(ev_cyc[i]),  32'(c));
            check({name, "_type"}, 32'(ev_type[i]), 32'(t));
            check({name, "_addr"}, 32'(ev_addr[i]), 32'(a));
            check({name, "_bank"}, 32'(ev_bank[i]), 32'(b));
        end else begin
            check({name, "_missing"}, 32'(ev_cyc.size()), 32'(i + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_act[6];
        int act_seen[$];

        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_bank  = '0;
        bus.req_r1    = '0;
        bus.req_r2    = '0;
        bus.req_t1    = '0;
        bus.req_t2    = '0;
        bus.cmd_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_cmd", 32'({bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_addr}), 32'd0);
        check("rst_done_busy", 32'({done, busy}), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_stats", stat_ops | stat_stall, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Two-row op, T1=T2=2
        clear_log();
        push(1'b0, 2, 4, 5, 2, 2);
        k = push_cyc;
        wait_done(1, 60);
        check("t1_nev", 32'(ev_cyc.size()), 32'd4);
        check_ev(0, "t1_act1", k + 2,  1, 4,    2);
        check_ev(1, "t1_pre1", k + 5,  2, 0,    2);
        check_ev(2, "t1_act2", k + 8,  1, 5,    2);
        check_ev(3, "t1_pre2", k + 17, 2, 1024, 2);
        if (done_q.size() > 0) check("t1_done_cyc", 32'(done_q[0]), 32'(k + 22));
        @(negedge clk);
        check("t1_idle", 32'({busy, level}), 32'd0);
        @(posedge clk);
        #2;

        // Single-row op, T1=0: no second ACT
        clear_log();
        push(1'b1, 3, 7, 9, 0, 0);
        k = push_cyc;
        wait_done(1, 60);
        check("t2_nev", 32'(ev_cyc.size()), 32'd2);
        if (ev_cyc.size() >= 2) begin
            check("t2_act_cyc",  32'(ev_cyc[0]),  32'(k + 2));
            check("t2_act_addr", 32'(ev_addr[0]), 32'd7);
            check("t2_act_bank", 32'(ev_bank[0]), 32'd3);
            check("t2_pre_cyc",  32'(ev_cyc[1]),  32'(k + 3));
            check("t2_pre_type", 32'(ev_type[1]), 32'd2);
        end
        if (done_q.size() > 0) check("t2_done_cyc", 32'(done_q[0]), 32'(k + 8));

        // Back-pressure for 5 cycles on PRE1
        clear_log();
        push(1'b0, 1, 3, 6, 0, 0);
        k = push_cyc;
        repeat (2) @(posedge clk);
        #2;
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold", 32'({bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_addr}),
                  32'({1'b1, 2'd2, 3'd1, 15'd0}));
            @(posedge clk);
            #2;
        end
        bus.cmd_ready = 1'b1;
        wait_done(1, 60);
        check_ev(0, "t3_act1", k + 2,  1, 3,    1);
        check_ev(1, "t3_pre1", k + 8,  2, 0,    1);
        check_ev(2, "t3_act2", k + 9,  1, 6,    1);
        check_ev(3, "t3_pre2", k + 18, 2, 1024, 1);
        if (done_q.size() > 0) check("t3_done_cyc", 32'(done_q[0]), 32'(k + 23));
        repeat (2) @(posedge clk);
        #2;
`ifdef COMPUTEDRAM_STATS_EN
        check("t3_stat_stall", stat_stall, 32'd5);
        check("t3_stat_ops",   stat_ops,   32'd3);
`else
        check("t3_stat_stall", stat_stall, 32'd0);
        check("t3_stat_ops",   stat_ops,   32'd0);
`endif

        // Queue fill with the FSM held in ACT1 by a blocker op
        clear_log();
        bus.cmd_ready = 1'b0;
        push(1'b1, 0, 20, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(1'b1, 0, 10 + i, 0, 0, 0);
        check("t4_level_full", 32'(level), 32'd4);
        check("t4_ready_full", 32'(bus.req_ready), 32'd0);
        fork
            push(1'b1, 0, 14, 0, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                bus.cmd_ready = 1'b1;
            end
        join
        wait_done(6, 200);
        exp_act = '{20, 10, 11, 12, 13, 14};
        for (int i = 0; i < ev_type.size(); i++) begin
            if (ev_type[i] == 1) act_seen.push_back(ev_addr[i]);
        end
        check("t4_nact", 32'(act_seen.size()), 32'd6);
        for (int i = 0; i < 6 && i < act_seen.size(); i++) begin
            check("t4_order", 32'(act_seen[i]), 32'(exp_act[i]));
        end
        check("t4_level_end", 32'(level), 32'd0);

        // Reset in WAIT_RAS abandons the op
        clear_log();
        push(1'b0, 5, 1, 2, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        check("t5_nev_pre", 32'(ev_cyc.size()), 32'd3);
        check("t5_busy_pre", 32'({busy, bus.cmd_valid}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("t5_rst_cmd", 32'({bus.cmd_valid, bus.cmd_type, bus.cmd_bank, bus.cmd_addr}), 32'd0);
        check("t5_rst_misc", 32'({done, busy, level}), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd1);
        check("t5_rst_stats", stat_ops | stat_stall, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("t5_no_done", 32'(done_q.size()), 32'd0);
        clear_log();
        push(1'b1, 6, 9, 0, 1, 0);
        k = push_cyc;
        wait_done(1, 60);
        check_ev(0, "t5_act", k + 2, 1, 9, 6);
        if (ev_cyc.size() >= 2) check("t5_pre_cyc", 32'(ev_cyc[1]), 32'(k + 4));
        if (done_q.size() > 0) check("t5_done_cyc", 32'(done_q[0]), 32'(k + 9));

`ifdef COMPUTEDRAM_STATS_EN
        // Saturation of the op counter
        @(negedge clk);
        force dut.r_stat_ops = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_stat_ops;
        clear_log();
        for (int i = 0; i < 3; i++) push(1'b1, 0, 30 + i, 0, 0, 0);
        wait_done(3, 100);
        repeat (2) @(posedge clk);
        #2;
        check("sat_stat_ops", stat_ops, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/computedram_seq.md
Name: computedram_seq

Overview:
- Parametrised successor to the single-shot ComputeDRAM R1/R2/T1/T2/vld/rdy request path.
- Accepts ComputeDRAM row-operation requests through a valid/ready queue of configurable depth, per bank and with selectable mode.
- Expands each request into timed ACT/PRE command sequences toward the PHY command arbiter; completion is pulsed per operation.
- Sits between user logic and the DRAM command mux in the sys_clk domain.

Parameters:
- ROW_W, 15, row address width (cmd_addr width).
- BA_W, 3, bank address width.
- T_W, 4, width of the T1/T2 violation timing fields.
- DEPTH, 4, request queue entries; power of 2, ≥2.
- TRAS, 8, cycles from final ACT accept to final PRE valid, minus 1.
- TRP, 4, cycles from final PRE accept to done, minus 1.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  queue not full.
- req_mode  in  1  0=two-row (ACT R1, PRE, ACT R2); 1=single-row (ACT R1, PRE only).
- req_bank  in  BA_W  target bank.
- req_r1  in  ROW_W  first row.
- req_r2  in  ROW_W  second row (ignored in mode 1).
- req_t1  in  T_W  ACT1→PRE1 gap.
- req_t2  in  T_W  PRE1→ACT2 gap.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  arbiter accepts command.
- cmd_type  out  2  1=ACT, 2=PRE, 0 when idle.
- cmd_bank  out  BA_W  command bank.
- cmd_addr  out  ROW_W  row for ACT; for PRE, bit 10 set only on final PRE (precharge-all).
- done  out  1  one-cycle pulse per completed op.
- busy  out  1  FSM not IDLE or queue non-empty.
- level  out  $clog2(DEPTH)+1  queue occupancy.
- stat_ops  out  32  completed ops (see optional feature).
- stat_stall  out  32  stall cycles (see optional feature).

Behaviour:
- Reset values (async, sys_rst_n=0): all outputs 0 except req_ready=1. Queue is emptied and the FSM goes to IDLE. Reset mid-sequence abandons the op with no done pulse.
- Queue: a push occurs on req_valid&req_ready. req_ready = level<DEPTH. Simultaneous push and pop when full is not allowed (ready=0). Push and pop in the same cycle leaves level unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ACT1, WAIT1, PRE1, WAIT2, ACT2, WAIT_RAS, PRE2, WAIT_RP, DONE.
- IDLE: if queue non-empty, pop into a working register and go to ACT1 next cycle. A push into an empty idle queue at cycle k gives ACT1 cmd_valid at k+2.
- Command handshake (ACT1, PRE1, ACT2, PRE2):
  - cmd_valid=1; cmd_type, cmd_bank and cmd_addr are held stable until cmd_ready.
  - The state advances on the accept cycle. cmd_valid never drops without an accept.
- Wait-state timing:
  - WAIT1: after ACT1 accept at cycle n, PRE1 is valid at n+1+T1.
  - WAIT2: after PRE1 accept at m, ACT2 is valid at m+1+T2.
  - T=0 gives back-to-back cycles.
- PRE1 carries cmd_addr=0.
- Mode 1: after PRE1 accept go straight to WAIT_RP; PRE2 is skipped.
- WAIT_RAS: PRE2 valid at ACT2-accept+1+TRAS. PRE2 carries cmd_addr bit10=1, other bits 0.
- WAIT_RP: DONE at final-PRE-accept+1+TRP.
- DONE: done=1 for one cycle, then IDLE. Back-to-back ops: done at d gives next ACT1 valid at d+2.
- Wait counters are T_W/$clog2 wide, load on the accept cycle and count down to 0; no overflow is possible.

Optional Feature:
- COMPUTEDRAM_STATS_EN defined:
  - stat_ops increments on each done.
  - stat_stall increments on each cycle with cmd_valid&!cmd_ready.
  - Both are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- Mode 0, bank 2, R1=4, R2=5, T1=2, T2=2, cmd_ready=1, push at k -> ACT(addr 4) at k+2, PRE(addr 0) at k+5, ACT(addr 5) at k+8, PRE(bit10=1) at k+17, done at k+22; cmd_bank=2 on all four.
- Mode 1, R1=7, T1=0 -> ACT(7) at k+2, PRE at k+3, done at k+8, no second ACT.
- Hold cmd_ready=0 for 5 cycles during PRE1 -> outputs stable, later timing shifts by 5, stat_stall=5 with COMPUTEDRAM_STATS_EN.
- Push 5 requests back-to-back with DEPTH=4 and the FSM stalled -> req_ready=0 once level=4; fifth accepted after first pop; five done pulses in push order.
- Assert sys_rst_n=0 during WAIT_RAS -> all outputs 0 immediately, level=0, no done; new request afterwards runs normally.
- Counter saturation (force stat_ops=0xFFFFFFFE, run 3 ops) -> 0xFFFFFFFF.
